snake_engine: RTL and testbench

SNAKE_ENGINE -- requirements
Module: snake_engine

---
 rtl/snake_pkg.sv | 30 +++
 rtl/snake_body_hit.sv | 26 ++
 rtl/snake_engine.sv | 181 ++++++++++++++++++
 tb/tb_snake_engine.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/snake_pkg.sv
// Shared types for the snake engine: move directions, game states and
// the reversal check used to reject 180-degree turns.
package snake_pkg;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_RIGHT = 2'd2,
    DIR_LEFT  = 2'd3
  } dir_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_OVER = 2'd2
  } state_t;

  function automatic dir_t opposite(input dir_t d);
    dir_t r;
    case (d)
      DIR_UP:    r = DIR_DOWN;
      DIR_DOWN:  r = DIR_UP;
      DIR_RIGHT: r = DIR_LEFT;
      DIR_LEFT:  r = DIR_RIGHT;
      default:   r = DIR_RIGHT;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/snake_body_hit.sv
// Parallel compare of one grid cell against every body segment; only
// segments below count take part.
module snake_body_hit #(
  parameter int unsigned MAX_LEN = 128,
  parameter int unsigned XW      = 6,
  parameter int unsigned YW      = 6,
  parameter int unsigned LW      = 8
) (
  input  logic [XW-1:0] cell_x,
  input  logic [YW-1:0] cell_y,
  input  logic [XW-1:0] seg_x [MAX_LEN],
  input  logic [YW-1:0] seg_y [MAX_LEN],
  input  logic [LW-1:0] count,
  output logic          hit_c
);

  always_comb begin
    hit_c = 1'b0;
    for (int unsigned i = 0; i < MAX_LEN; i++) begin
      if ((LW'(i) < count) && (seg_x[i] == cell_x) && (seg_y[i] == cell_y)) begin
        hit_c = 1'b1;
      end
    end
  end

endmodule

// File: rtl/snake_engine.sv
// Snake game engine: body shift register, direction latch, move/collision
// logic and a registered pixel query against the body.
module snake_engine
  import snake_pkg::*;
#(
  parameter int unsigned GRID_W   = 64,
  parameter int unsigned GRID_H   = 48,
  parameter int unsigned MAX_LEN  = 128,
  parameter int unsigned INIT_LEN = 6,
  parameter int unsigned WRAP     = 0,
  localparam int unsigned XW = $clog2(GRID_W),
  localparam int unsigned YW = $clog2(GRID_H),
  localparam int unsigned LW = $clog2(MAX_LEN + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          tick,
  input  logic [1:0]    dir_in,
  input  logic          dir_valid,
  input  logic [XW-1:0] apple_x,
  input  logic [YW-1:0] apple_y,
  input  logic [XW-1:0] query_x,
  input  logic [YW-1:0] query_y,
  output logic          query_hit,
  output logic [XW-1:0] head_x,
  output logic [YW-1:0] head_y,
  output logic [LW-1:0] length,
  output logic          ate,
  output logic          game_over,
  output logic          running
);

  state_t        state, state_next;
  dir_t          cur_dir, pending_dir, eff_dir;
  logic [XW-1:0] seg_x [MAX_LEN];
  logic [YW-1:0] seg_y [MAX_LEN];

  logic [XW-1:0] new_x;
  logic [YW-1:0] new_y;
  logic          edge_hit, wall_hit, apple_match, grow;
  logic          move_fire, collision, self_hit_c, query_hit_c;
  logic [LW-1:0] self_count;

  assign head_x = seg_x[0];
  assign head_y = seg_y[0];

  // Next head cell; edge_hit flags a step off the grid (value is wrapped).
  always_comb begin
    new_x    = seg_x[0];
    new_y    = seg_y[0];
    edge_hit = 1'b0;
    case (pending_dir)
      DIR_UP: begin
        if (seg_y[0] == '0) begin
          edge_hit = 1'b1;
          new_y    = YW'(GRID_H - 1);
        end else begin
          new_y = seg_y[0] - YW'(1);
        end
      end
      DIR_DOWN: begin
        if (seg_y[0] == YW'(GRID_H - 1)) begin
          edge_hit = 1'b1;
          new_y    = '0;
        end else begin
          new_y = seg_y[0] + YW'(1);
        end
      end
      DIR_RIGHT: begin
        if (seg_x[0] == XW'(GRID_W - 1)) begin
          edge_hit = 1'b1;
          new_x    = '0;
        end else begin
          new_x = seg_x[0] + XW'(1);
        end
      end
      DIR_LEFT: begin
        if (seg_x[0] == '0) begin
          edge_hit = 1'b1;
          new_x    = XW'(GRID_W - 1);
        end else begin
          new_x = seg_x[0] - XW'(1);
        end
      end
      default: begin
        new_x = seg_x[0];
      end
    endcase
  end

  assign wall_hit    = edge_hit && (WRAP == 0);
  assign apple_match = (new_x == apple_x) && (new_y == apple_y);
  assign grow        = apple_match && (length < LW'(MAX_LEN));
  // The tail vacates its cell on a plain move, so it only blocks when growing.
  assign self_count  = grow ? length : (length - LW'(1));
  assign move_fire   = (state == ST_RUN) && tick;
  assign collision   = move_fire && (wall_hit || self_hit_c);
  assign eff_dir     = move_fire ? pending_dir : cur_dir;

  snake_body_hit #(
    .MAX_LEN(MAX_LEN), .XW(XW), .YW(YW), .LW(LW)
  ) u_query_hit (
    .cell_x(query_x),
    .cell_y(query_y),
    .seg_x (seg_x),
    .seg_y (seg_y),
    .count (length),
    .hit_c (query_hit_c)
  );

  snake_body_hit #(
    .MAX_LEN(MAX_LEN), .XW(XW), .YW(YW), .LW(LW)
  ) u_self_hit (
    .cell_x(new_x),
    .cell_y(new_y),
    .seg_x (seg_x),
    .seg_y (seg_y),
    .count (self_count),
    .hit_c (self_hit_c)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (start)     state_next = ST_RUN;
      ST_RUN:  if (collision) state_next = ST_OVER;
      ST_OVER: if (start)     state_next = ST_IDLE;
      default:                state_next = ST_IDLE;
    endcase
  end

  // Body, direction and status registers; reset wins over any pending move.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cur_dir     <= DIR_RIGHT;
      pending_dir <= DIR_RIGHT;
      length      <= LW'(INIT_LEN);
      for (int unsigned i = 0; i < MAX_LEN; i++) begin
        seg_x[i] <= (i < INIT_LEN) ? XW'(INIT_LEN - 1 - i) : '0;
        seg_y[i] <= '0;
      end
      ate       <= 1'b0;
      game_over <= 1'b0;
      running   <= 1'b0;
      query_hit <= 1'b0;
    end else begin
      ate <= 1'b0;
      if (move_fire) begin
        cur_dir <= pending_dir;
        if (!collision) begin
          for (int unsigned i = 1; i < MAX_LEN; i++) begin
            seg_x[i] <= seg_x[i-1];
            seg_y[i] <= seg_y[i-1];
          end
          seg_x[0] <= new_x;
          seg_y[0] <= new_y;
          if (grow) begin
            length <= length + LW'(1);
          end
          ate <= apple_match;
        end
      end
      if (dir_valid && (dir_in != opposite(eff_dir))) begin
        pending_dir <= dir_t'(dir_in);
      end
      game_over <= (state_next == ST_OVER);
      running   <= (state_next == ST_RUN);
      query_hit <= query_hit_c;
    end
  end

endmodule

// File: tb/tb_snake_engine.sv
// Bench for snake_engine: a non-wrapping and a wrapping instance share
// stimulus; directed scenarios plus a random run against a list-based model.
module tb_snake_engine;

  localparam int GW = 64;
  localparam int GH = 48;
  localparam int ML = 128;
  localparam int IL = 6;
  localparam int XW = 6;
  localparam int YW = 6;
  localparam int LW = 8;

  logic          clk = 1'b0;
  logic          reset, start, tick, dir_valid;
  logic [1:0]    dir_in;
  logic [XW-1:0] apple_x, query_x;
  logic [YW-1:0] apple_y, query_y;

  logic          qhit [2];
  logic [XW-1:0] hx   [2];
  logic [YW-1:0] hy   [2];
  logic [LW-1:0] len  [2];
  logic          ate  [2];
  logic          gover[2];
  logic          run  [2];

  int total = 0;
  int bad   = 0;

  // Model: body as a list of cells, head first.
  int bx [2][ML];
  int by [2][ML];
  int mlen[2], mstate[2], mcur[2], mpend[2];
  bit eate[2], eqhit[2];

  always #5 clk = ~clk;

  snake_engine #(.GRID_W(GW), .GRID_H(GH), .MAX_LEN(ML), .INIT_LEN(IL), .WRAP(0)) u_dut0 (
    .clk(clk), .reset(reset), .start(start), .tick(tick), .dir_in(dir_in),
    .dir_valid(dir_valid), .apple_x(apple_x), .apple_y(apple_y),
    .query_x(query_x), .query_y(query_y), .query_hit(qhit[0]),
    .head_x(hx[0]), .head_y(hy[0]), .length(len[0]), .ate(ate[0]),
    .game_over(gover[0]), .running(run[0]));

  snake_engine #(.GRID_W(GW), .GRID_H(GH), .MAX_LEN(ML), .INIT_LEN(IL), .WRAP(1)) u_dut1 (
    .clk(clk), .reset(reset), .start(start), .tick(tick), .dir_in(dir_in),
    .dir_valid(dir_valid), .apple_x(apple_x), .apple_y(apple_y),
    .query_x(query_x), .query_y(query_y), .query_hit(qhit[1]),
    .head_x(hx[1]), .head_y(hy[1]), .length(len[1]), .ate(ate[1]),
    .game_over(gover[1]), .running(run[1]));

  function automatic int opp(input int d);
    case (d)
      0: return 1;
      1: return 0;
      2: return 3;
      default: return 2;
    endcase
  endfunction

  task automatic model_reset();
    for (int w = 0; w < 2; w++) begin
      mstate[w] = 0; mcur[w] = 2; mpend[w] = 2; mlen[w] = IL;
      eate[w] = 0; eqhit[w] = 0;
      for (int i = 0; i < ML; i++) begin
        bx[w][i] = (i < IL) ? IL - 1 - i : 0;
        by[w][i] = 0;
      end
    end
  endtask

  // w=0 is the edge-kills instance, w=1 the wrapping one.
  task automatic model_step();
    for (int w = 0; w < 2; w++) begin
      int nx, ny;
      bit out, coll, grw, am;
      eqhit[w] = 0;
      for (int i = 0; i < mlen[w]; i++)
        if (bx[w][i] == int'(query_x) && by[w][i] == int'(query_y)) eqhit[w] = 1;
      eate[w] = 0;
      if (mstate[w] == 1) begin
        if (tick) begin
          nx = bx[w][0]; ny = by[w][0];
          case (mpend[w])
            0: ny = ny - 1;
            1: ny = ny + 1;
            2: nx = nx + 1;
            default: nx = nx - 1;
          endcase
          out = (nx < 0) || (nx >= GW) || (ny < 0) || (ny >= GH);
          if (w == 1) begin
            nx = (nx + GW) % GW;
            ny = (ny + GH) % GH;
          end
          am   = (nx == int'(apple_x)) && (ny == int'(apple_y));
          grw  = am && (mlen[w] < ML);
          coll = (w == 0) && out;
          for (int i = 0; i < mlen[w]; i++)
            if (bx[w][i] == nx && by[w][i] == ny && (i < mlen[w] - 1 || grw)) coll = 1;
          if (coll) begin
            mstate[w] = 2;
          end else begin
            for (int i = mlen[w]; i > 0; i--) begin
              if (i < ML) begin
                bx[w][i] = bx[w][i-1];
                by[w][i] = by[w][i-1];
              end
            end
            bx[w][0] = nx; by[w][0] = ny;
            if (grw) mlen[w] = mlen[w] + 1;
            eate[w] = am;
          end
          mcur[w] = mpend[w];
        end
      end else if (start) begin
        mstate[w] = (mstate[w] == 0) ? 1 : 0;
      end
      if (dir_valid && int'(dir_in) != opp(mcur[w])) mpend[w] = int'(dir_in);
    end
  endtask

  // One clock: model follows the inputs the DUT samples, strobes then drop.
  task automatic cycle();
    if (!reset) model_reset();
    else model_step();
    @(posedge clk);
    #1;
    start = 0; tick = 0; dir_valid = 0;
  endtask

  task automatic do_reset();
    reset = 0;
    cycle();
    reset = 1;
  endtask

  task automatic turn_and_tick(input logic [1:0] d);
    dir_in = d; dir_valid = 1;
    cycle();
    tick = 1;
    cycle();
  endtask

  task automatic test_reset();
    reset = 0;
    cycle();
    reset = 1;
    for (int w = 0; w < 2; w++) begin
      total++; if (hx[w] !== 6'd5) begin bad++; $display("FAIL reset_head_x dut%0d: got %0d want 5", w, hx[w]); end
      total++; if (hy[w] !== 6'd0) begin bad++; $display("FAIL reset_head_y dut%0d: got %0d want 0", w, hy[w]); end
      total++; if (len[w] !== 8'd6) begin bad++; $display("FAIL reset_length dut%0d: got %0d want 6", w, len[w]); end
      total++; if ({ate[w], gover[w], run[w], qhit[w]} !== 4'b0000) begin
        bad++; $display("FAIL reset_flags dut%0d: got %b want 0000", w, {ate[w], gover[w], run[w], qhit[w]});
      end
    end
  endtask

  task automatic test_basic_run();
    do_reset();
    start = 1;
    cycle();
    total++; if (run[0] !== 1'b1) begin bad++; $display("FAIL start_running: got %b want 1", run[0]); end
    for (int k = 0; k < 3; k++) begin tick = 1; cycle(); end
    total++; if (hx[0] !== 6'd8 || hy[0] !== 6'd0) begin
      bad++; $display("FAIL three_ticks_head: got (%0d,%0d) want (8,0)", hx[0], hy[0]);
    end
    total++; if (len[0] !== 8'd6) begin bad++; $display("FAIL three_ticks_length: got %0d want 6", len[0]); end
    query_x = 6'd3; query_y = 6'd0;
    cycle();
    total++; if (qhit[0] !== 1'b1) begin bad++; $display("FAIL query_tail_3_0: got %b want 1", qhit[0]); end
    query_x = 6'd2;
    cycle();
    total++; if (qhit[0] !== 1'b0) begin bad++; $display("FAIL query_vacated_2_0: got %b want 0", qhit[0]); end
  endtask

  task automatic test_no_reverse();
    dir_in = 2'd3; dir_valid = 1;
    cycle();
    tick = 1;
    cycle();
    total++; if (hx[0] !== 6'd9 || hy[0] !== 6'd0) begin
      bad++; $display("FAIL reverse_discard: got (%0d,%0d) want (9,0)", hx[0], hy[0]);
    end
    turn_and_tick(2'd1);
    total++; if (hx[0] !== 6'd9 || hy[0] !== 6'd1) begin
      bad++; $display("FAIL turn_down: got (%0d,%0d) want (9,1)", hx[0], hy[0]);
    end
  endtask

  task automatic test_apple();
    apple_x = 6'd6; apple_y = 6'd0;
    do_reset();
    start = 1;
    cycle();
    tick = 1;
    cycle();
    total++; if (ate[0] !== 1'b1) begin bad++; $display("FAIL apple_ate: got %b want 1", ate[0]); end
    total++; if (len[0] !== 8'd7) begin bad++; $display("FAIL apple_length: got %0d want 7", len[0]); end
    query_x = 6'd0; query_y = 6'd0;
    cycle();
    total++; if (ate[0] !== 1'b0) begin bad++; $display("FAIL apple_pulse_width: got %b want 0", ate[0]); end
    total++; if (qhit[0] !== 1'b1) begin bad++; $display("FAIL apple_tail_kept: got %b want 1", qhit[0]); end
    apple_x = 6'd0; apple_y = 6'd40;
  endtask

  task automatic test_edges();
    do_reset();
    start = 1;
    cycle();
    dir_in = 2'd1; dir_valid = 1;
    cycle();
    for (int k = 0; k < 5; k++) begin tick = 1; cycle(); end
    dir_in = 2'd2; dir_valid = 1;
    cycle();
    for (int k = 0; k < 58; k++) begin tick = 1; cycle(); end
    for (int w = 0; w < 2; w++) begin
      total++; if (hx[w] !== 6'd63 || hy[w] !== 6'd5) begin
        bad++; $display("FAIL edge_approach dut%0d: got (%0d,%0d) want (63,5)", w, hx[w], hy[w]);
      end
    end
    tick = 1;
    cycle();
    total++; if (gover[0] !== 1'b1 || run[0] !== 1'b0) begin
      bad++; $display("FAIL wall_game_over: got go=%b run=%b want go=1 run=0", gover[0], run[0]);
    end
    total++; if (hx[1] !== 6'd0 || hy[1] !== 6'd5 || gover[1] !== 1'b0) begin
      bad++; $display("FAIL wrap_head: got (%0d,%0d) go=%b want (0,5) go=0", hx[1], hy[1], gover[1]);
    end
    for (int k = 0; k < 2; k++) begin tick = 1; cycle(); end
    total++; if (hx[0] !== 6'd63 || hy[0] !== 6'd5 || gover[0] !== 1'b1) begin
      bad++; $display("FAIL over_ignores_tick: got (%0d,%0d) go=%b want (63,5) go=1", hx[0], hy[0], gover[0]);
    end
    total++; if (hx[1] !== 6'd2) begin bad++; $display("FAIL wrap_continue: got %0d want 2", hx[1]); end
    start = 1;
    cycle();
    total++; if (gover[0] !== 1'b0 || run[0] !== 1'b0) begin
      bad++; $display("FAIL over_to_idle: got go=%b run=%b want 0 0", gover[0], run[0]);
    end
    total++; if (run[1] !== 1'b1) begin bad++; $display("FAIL start_in_run: got %b want 1", run[1]); end
  endtask

  task automatic test_tail_chase();
    do_reset();
    start = 1;
    cycle();
    turn_and_tick(2'd1);
    turn_and_tick(2'd3);
    tick = 1;
    cycle();
    turn_and_tick(2'd0);
    total++; if (gover[0] !== 1'b0 || hx[0] !== 6'd3 || hy[0] !== 6'd0) begin
      bad++; $display("FAIL tail_move_ok: got (%0d,%0d) go=%b want (3,0) go=0", hx[0], hy[0], gover[0]);
    end
    apple_x = 6'd4; apple_y = 6'd0;
    turn_and_tick(2'd2);
    total++; if (gover[0] !== 1'b1 || hx[0] !== 6'd3 || len[0] !== 8'd6 || ate[0] !== 1'b0) begin
      bad++; $display("FAIL tail_grow_collide: got (%0d,%0d) len=%0d go=%b ate=%b want (3,0) len=6 go=1 ate=0",
                      hx[0], hy[0], len[0], gover[0], ate[0]);
    end
    apple_x = 6'd0; apple_y = 6'd40;
  endtask

  task automatic test_random();
    int ax, ay;
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      reset     = ($urandom_range(0, 599) != 0);
      start     = ($urandom_range(0, 15) == 0);
      tick      = ($urandom_range(0, 2) == 0);
      dir_valid = ($urandom_range(0, 3) == 0);
      dir_in    = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) begin
        ax = bx[0][0] + $urandom_range(0, 4) - 2;
        ay = by[0][0] + $urandom_range(0, 4) - 2;
        apple_x = XW'((ax < 0) ? 0 : (ax > GW - 1) ? GW - 1 : ax);
        apple_y = YW'((ay < 0) ? 0 : (ay > GH - 1) ? GH - 1 : ay);
      end
      if ($urandom_range(0, 1) == 0) begin
        ax = $urandom_range(0, mlen[0] - 1);
        query_x = XW'(bx[0][ax]); query_y = YW'(by[0][ax]);
      end else begin
        query_x = XW'($urandom_range(0, GW - 1)); query_y = YW'($urandom_range(0, GH - 1));
      end
      cycle();
      reset = 1;
      for (int w = 0; w < 2; w++) begin
        total++; if (hx[w] !== XW'(bx[w][0]) || hy[w] !== YW'(by[w][0])) begin
          bad++; $display("FAIL rand_head dut%0d n=%0d: got (%0d,%0d) want (%0d,%0d)", w, n, hx[w], hy[w], bx[w][0], by[w][0]);
        end
        total++; if (len[w] !== LW'(mlen[w])) begin
          bad++; $display("FAIL rand_length dut%0d n=%0d: got %0d want %0d", w, n, len[w], mlen[w]);
        end
        total++; if (ate[w] !== eate[w]) begin
          bad++; $display("FAIL rand_ate dut%0d n=%0d: got %b want %b", w, n, ate[w], eate[w]);
        end
        total++; if (gover[w] !== (mstate[w] == 2) || run[w] !== (mstate[w] == 1)) begin
          bad++; $display("FAIL rand_state dut%0d n=%0d: got go=%b run=%b want state %0d", w, n, gover[w], run[w], mstate[w]);
        end
        total++; if (qhit[w] !== eqhit[w]) begin
          bad++; $display("FAIL rand_query dut%0d n=%0d: got %b want %b", w, n, qhit[w], eqhit[w]);
        end
      end
    end
  endtask

  initial begin
    reset = 0; start = 0; tick = 0; dir_valid = 0; dir_in = 2'd2;
    apple_x = 6'd0; apple_y = 6'd40; query_x = 6'd0; query_y = 6'd0;
    model_reset();
    @(negedge clk);
    test_reset();
    test_basic_run();
    test_no_reverse();
    test_apple();
    test_edges();
    test_tail_chase();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, bad=%0d", bad + 1);
    $fatal(1, "watchdog expired");
  end

endmodule
